// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the data-memory access controller, its two requesters
// (pipeline MEM stage and debug/loader port) and the single-port data memory.
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p_re;
   logic              p_we;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic [DATA_W-1:0] p_rdata;
   logic              p_done;
   logic              p_stall;

   logic              d_re;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   // Controller view: takes requests and memory read data, drives everything else.
   modport slave (
      input  p_re, p_we, p_addr, p_wdata,
      output p_rdata, p_done, p_stall,
      input  d_re, d_we, d_addr, d_wdata,
      output d_rdata, d_done,
      output mem_addr, mem_wdata, mem_re, mem_we,
      input  mem_rdata,
      output busy
   );

   // Environment view: requesters plus the memory itself.
   modport master (
      output p_re, p_we, p_addr, p_wdata,
      input  p_rdata, p_done, p_stall,
      output d_re, d_we, d_addr, d_wdata,
      input  d_rdata, d_done,
      input  mem_addr, mem_wdata, mem_re, mem_we,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates pipeline vs debug requests and holds
// each granted access on the single-port memory for WAIT_CYCLES+1 cycles.
module dmem_access_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int WAIT_CYCLES  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   dmem_access_ctrl_if.slave bus
);
   localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [3:0]        wait_cnt_r;
   logic [3:0]        wait_cnt_nxt_s;
   logic [3:0]        starve_cnt_r;
   logic [3:0]        starve_cnt_nxt_s;
   logic              owner_dbg_r;
   logic              owner_dbg_nxt_s;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [ADDR_W-1:0] mem_addr_nxt_s;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] mem_wdata_nxt_s;
   logic              mem_re_r;
   logic              mem_re_nxt_s;
   logic              mem_we_r;
   logic              mem_we_nxt_s;
   logic [DATA_W-1:0] p_rdata_r;
   logic [DATA_W-1:0] p_rdata_nxt_s;
   logic [DATA_W-1:0] d_rdata_r;
   logic [DATA_W-1:0] d_rdata_nxt_s;
   logic              p_done_r;
   logic              p_done_nxt_s;
   logic              d_done_r;
   logic              d_done_nxt_s;

   logic              pipe_req_s;
   logic              dbg_req_s;
   logic              grant_dbg_s;

   assign pipe_req_s  = bus.p_re | bus.p_we;
   assign dbg_req_s   = bus.d_re | bus.d_we;
   // Debug wins when alone, or when the pipeline has starved it long enough.
   assign grant_dbg_s = dbg_req_s & (~pipe_req_s | (starve_cnt_r == STARVE_MAX));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pipe_req_s | dbg_req_s) begin
               state_nxt_s = ST_BUSY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (wait_cnt_r == 4'd0) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the latched access, counters, read data and done pulses.
   always_comb begin
      wait_cnt_nxt_s   = wait_cnt_r;
      starve_cnt_nxt_s = starve_cnt_r;
      owner_dbg_nxt_s  = owner_dbg_r;
      mem_addr_nxt_s   = mem_addr_r;
      mem_wdata_nxt_s  = mem_wdata_r;
      mem_re_nxt_s     = mem_re_r;
      mem_we_nxt_s     = mem_we_r;
      p_rdata_nxt_s    = p_rdata_r;
      d_rdata_nxt_s    = d_rdata_r;
      p_done_nxt_s     = 1'b0;
      d_done_nxt_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pipe_req_s | dbg_req_s) begin
               wait_cnt_nxt_s = WAIT_LOAD;
               if (grant_dbg_s) begin
                  owner_dbg_nxt_s  = 1'b1;
                  mem_addr_nxt_s   = bus.d_addr;
                  mem_wdata_nxt_s  = bus.d_wdata;
                  mem_re_nxt_s     = bus.d_re & ~bus.d_we;
                  mem_we_nxt_s     = bus.d_we;
                  starve_cnt_nxt_s = 4'd0;
               end else begin
                  owner_dbg_nxt_s = 1'b0;
                  mem_addr_nxt_s  = bus.p_addr;
                  mem_wdata_nxt_s = bus.p_wdata;
                  mem_re_nxt_s    = bus.p_re & ~bus.p_we;
                  mem_we_nxt_s    = bus.p_we;
                  // Only a contended pipeline grant counts against the debug port.
                  if (dbg_req_s && (starve_cnt_r != STARVE_MAX)) begin
                     starve_cnt_nxt_s = starve_cnt_r + 4'd1;
                  end else begin
                     starve_cnt_nxt_s = starve_cnt_r;
                  end
               end
            end else begin
               mem_re_nxt_s = 1'b0;
               mem_we_nxt_s = 1'b0;
            end
         end
         ST_BUSY: begin
            if (wait_cnt_r != 4'd0) begin
               wait_cnt_nxt_s = wait_cnt_r - 4'd1;
            end else begin
               if (mem_re_r && owner_dbg_r) begin
                  d_rdata_nxt_s = bus.mem_rdata;
               end else if (mem_re_r) begin
                  p_rdata_nxt_s = bus.mem_rdata;
               end else begin
                  p_rdata_nxt_s = p_rdata_r;
               end
               p_done_nxt_s = ~owner_dbg_r;
               d_done_nxt_s = owner_dbg_r;
               mem_re_nxt_s = 1'b0;
               mem_we_nxt_s = 1'b0;
            end
         end
         ST_DONE: begin
            mem_re_nxt_s = 1'b0;
            mem_we_nxt_s = 1'b0;
         end
         default: begin
            mem_re_nxt_s = 1'b0;
            mem_we_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath registers; reset aborts any access in flight without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_r   <= 4'd0;
         starve_cnt_r <= 4'd0;
         owner_dbg_r  <= 1'b0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
         mem_re_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         p_rdata_r    <= '0;
         d_rdata_r    <= '0;
         p_done_r     <= 1'b0;
         d_done_r     <= 1'b0;
      end else begin
         wait_cnt_r   <= wait_cnt_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
         owner_dbg_r  <= owner_dbg_nxt_s;
         mem_addr_r   <= mem_addr_nxt_s;
         mem_wdata_r  <= mem_wdata_nxt_s;
         mem_re_r     <= mem_re_nxt_s;
         mem_we_r     <= mem_we_nxt_s;
         p_rdata_r    <= p_rdata_nxt_s;
         d_rdata_r    <= d_rdata_nxt_s;
         p_done_r     <= p_done_nxt_s;
         d_done_r     <= d_done_nxt_s;
      end
   end

   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_re    = mem_re_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.p_rdata   = p_rdata_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.p_done    = p_done_r;
   assign bus.d_done    = d_done_r;
   // Low in the done cycle so the pipeline advances on that edge.
   assign bus.p_stall   = pipe_req_s & ~p_done_r;
   assign bus.busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl (WAIT_CYCLES=2, STARVE_LIMIT=2) with a
// small behavioural data memory behind the controller.
module tb_dmem_access_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] mem_model [0:255];

   dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_access_ctrl #(
      .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2), .STARVE_LIMIT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem_model[bus.mem_addr[7:0]];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_model[8'h10] <= 32'hDEADBEEF;
         mem_model[8'h30] <= 32'hCAFEF00D;
      end else if (bus.mem_we === 1'b1) begin
         mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the selected done pulse, tallying memory enables and stall.
   task automatic wait_done(input bit dbg, output int lat, output int re_cnt,
                            output int we_cnt, output int stall_cnt,
                            output logic [31:0] first_addr);
      bit seen;
      lat = -1; re_cnt = 0; we_cnt = 0; stall_cnt = 0; first_addr = 32'd0; seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.mem_re === 1'b1) re_cnt++;
         if (bus.mem_we === 1'b1) we_cnt++;
         if (bus.p_stall === 1'b1) stall_cnt++;
         if (!seen && (bus.mem_re === 1'b1 || bus.mem_we === 1'b1)) begin
            first_addr = bus.mem_addr;
            seen = 1'b1;
         end
         if ((dbg ? bus.d_done : bus.p_done) === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, rc, wc, sc, nd;
      logic [31:0] fa;
      logic [5:0]  order;
      int          t [6];

      rst = 1'b1;
      bus.p_re = 1'b0; bus.p_we = 1'b0; bus.p_addr = 32'd0; bus.p_wdata = 32'd0;
      bus.d_re = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_mem_re", bus.mem_re, 1'b0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chk1("rst_p_done", bus.p_done, 1'b0);
      chk1("rst_d_done", bus.d_done, 1'b0);
      chk1("rst_p_stall", bus.p_stall, 1'b0);
      chk("rst_p_rdata", bus.p_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Pipeline read of 0x10: done on the 4th falling edge after the request.
      bus.p_addr = 32'h10; bus.p_re = 1'b1;
      #1 chk1("t1_stall_on_req", bus.p_stall, 1'b1);
      wait_done(1'b0, lat, rc, wc, sc, fa);
      chk("t1_latency", lat, 32'd4);
      chk("t1_re_cycles", rc, 32'd3);
      chk("t1_we_cycles", wc, 32'd0);
      chk("t1_stall_cycles", sc, 32'd3);
      chk("t1_addr", fa, 32'h10);
      chk("t1_rdata", bus.p_rdata, 32'hDEADBEEF);
      chk1("t1_stall_in_done", bus.p_stall, 1'b0);
      bus.p_re = 1'b0;
      @(negedge clk);
      chk1("t1_done_single", bus.p_done, 1'b0);
      chk1("t1_idle", bus.busy, 1'b0);

      // Pipeline write of 0x12345678 to 0x20, then read back.
      bus.p_addr = 32'h20; bus.p_wdata = 32'h12345678; bus.p_we = 1'b1;
      wait_done(1'b0, lat, rc, wc, sc, fa);
      chk("t2_latency", lat, 32'd4);
      chk("t2_we_cycles", wc, 32'd3);
      chk("t2_re_cycles", rc, 32'd0);
      chk("t2_addr", fa, 32'h20);
      bus.p_we = 1'b0;
      @(negedge clk);
      chk("t2_mem_word", mem_model[8'h20], 32'h12345678);
      bus.p_re = 1'b1;
      wait_done(1'b0, lat, rc, wc, sc, fa);
      chk("t2_readback", bus.p_rdata, 32'h12345678);
      bus.p_re = 1'b0;
      @(negedge clk);

      // Simultaneous requests: pipeline first, debug WAIT_CYCLES+3 later.
      bus.p_addr = 32'h10; bus.p_re = 1'b1;
      bus.d_addr = 32'h30; bus.d_re = 1'b1;
      wait_done(1'b0, lat, rc, wc, sc, fa);
      chk("t3_p_latency", lat, 32'd4);
      chk("t3_p_first_addr", fa, 32'h10);
      chk1("t3_no_d_done", bus.d_done, 1'b0);
      bus.p_re = 1'b0;
      wait_done(1'b1, lat, rc, wc, sc, fa);
      chk("t3_d_gap", lat, 32'd5);
      chk("t3_d_addr", fa, 32'h30);
      chk("t3_d_rdata", bus.d_rdata, 32'hCAFEF00D);
      chk("t3_p_rdata_kept", bus.p_rdata, 32'hDEADBEEF);
      bus.d_re = 1'b0;
      @(negedge clk);

      // Continuous contention with STARVE_LIMIT=2: grants P,P,D,P,P,D.
      bus.p_re = 1'b1; bus.d_re = 1'b1;
      order = 6'd0; nd = 0;
      for (int k = 1; k <= 40 && nd < 6; k++) begin
         @(negedge clk);
         if (bus.p_done === 1'b1) begin
            t[nd] = k; nd++;
         end else if (bus.d_done === 1'b1) begin
            order[nd] = 1'b1; t[nd] = k; nd++;
         end
      end
      bus.p_re = 1'b0; bus.d_re = 1'b0;
      chk("t4_grants", nd, 32'd6);
      chk("t4_order", {26'd0, order}, 32'b100100);
      chk("t4_throughput", t[1] - t[0], 32'd5);
      chk("t4_after_dbg", t[3] - t[2], 32'd5);
      @(negedge clk);
      chk1("t4_idle", bus.busy, 1'b0);

      // Reset in the second BUSY cycle aborts the access.
      bus.p_addr = 32'h10; bus.p_re = 1'b1;
      repeat (2) @(negedge clk);
      chk1("t5_busy_before", bus.mem_re, 1'b1);
      rst = 1'b1;
      #1;
      chk1("t5_mem_re_drop", bus.mem_re, 1'b0);
      chk1("t5_mem_we_drop", bus.mem_we, 1'b0);
      chk1("t5_busy_drop", bus.busy, 1'b0);
      chk("t5_p_rdata_clr", bus.p_rdata, 32'd0);
      chk("t5_mem_addr_clr", bus.mem_addr, 32'd0);
      @(negedge clk);
      chk1("t5_no_done_a", bus.p_done, 1'b0);
      @(negedge clk);
      chk1("t5_no_done_b", bus.p_done, 1'b0);
      rst = 1'b0;
      wait_done(1'b0, lat, rc, wc, sc, fa);
      chk("t5_latency", lat, 32'd4);
      chk("t5_re_cycles", rc, 32'd3);
      chk("t5_rdata", bus.p_rdata, 32'hDEADBEEF);
      bus.p_re = 1'b0;
      @(negedge clk);

      // re and we together are a write; read data stays put.
      bus.p_addr = 32'h40; bus.p_wdata = 32'hA5A5A5A5; bus.p_re = 1'b1; bus.p_we = 1'b1;
      wait_done(1'b0, lat, rc, wc, sc, fa);
      chk("t6_latency", lat, 32'd4);
      chk("t6_re_cycles", rc, 32'd0);
      chk("t6_we_cycles", wc, 32'd3);
      chk("t6_rdata_kept", bus.p_rdata, 32'hDEADBEEF);
      bus.p_re = 1'b0; bus.p_we = 1'b0;
      @(negedge clk);
      chk("t6_mem_word", mem_model[8'h40], 32'hA5A5A5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle access sequencer and two-way arbiter for the single-port data memory in the memory stage.
- Requesters: the pipeline MEM stage (p_*) and a debug/loader port (d_*).
- Latches the winning request, holds the memory address and controls for a fixed wait-state count, and returns read data with a one-cycle done pulse.
- Stalls the pipeline until its access completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, extra memory wait states (0..15); each access holds the memory for WAIT_CYCLES+1 cycles.
- STARVE_LIMIT, 4, consecutive contended pipeline grants before the debug port is forced a grant (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p_re  in  1  pipeline read request (MemRead).
- p_we  in  1  pipeline write request (MemWrite).
- p_addr  in  ADDR_W  pipeline address (ALU result).
- p_wdata  in  DATA_W  pipeline store data.
- p_rdata  out  DATA_W  pipeline load data, registered.
- p_done  out  1  one-cycle completion pulse, pipeline.
- p_stall  out  1  combinational: (p_re|p_we) & ~p_done.
- d_re  in  1  debug read request.
- d_we  in  1  debug write request.
- d_addr  in  ADDR_W  debug address.
- d_wdata  in  DATA_W  debug write data.
- d_rdata  out  DATA_W  debug read data, registered.
- d_done  out  1  one-cycle completion pulse, debug.
- mem_addr  out  ADDR_W  address to data memory.
- mem_wdata  out  DATA_W  write data to data memory.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data, valid during the last BUSY cycle.
- busy  out  1  high in BUSY and DONE states.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_re, mem_we, p_done, d_done = 0.
  - p_rdata, d_rdata = 0.
  - mem_addr, mem_wdata = 0.
  - wait counter = 0; starve counter = 0.
  - An access in flight is aborted with no done pulse.
- Request definition: a port requests when re|we is high. If re and we are both high, the access is a write; that port's rdata is unchanged.
- Requesters hold address, data and controls stable until their done pulse, and drop or replace the request in the done cycle.
- State IDLE:
  - No request: stay IDLE; all mem_* enables 0.
  - Request present: arbitrate, latch owner/addr/wdata/re/we, load wait counter = WAIT_CYCLES, go to BUSY.
- Arbitration:
  - Pipeline wins by default.
  - Debug wins if it is the only requester, or if starve counter == STARVE_LIMIT.
  - Pipeline grant while debug is also requesting: starve counter += 1 (saturates at STARVE_LIMIT).
  - Any debug grant clears the starve counter.
  - Uncontended pipeline grant leaves the starve counter unchanged.
- State BUSY:
  - mem_addr/mem_wdata/mem_re/mem_we driven from latched registers (registered, valid the first BUSY cycle).
  - Counter != 0: decrement, stay BUSY.
  - Counter == 0 (on that edge):
    - If read: capture mem_rdata into the owner's rdata.
    - Set the owner's done = 1, clear mem_re/mem_we, go to DONE.
  - Total BUSY cycles = WAIT_CYCLES+1.
- State DONE:
  - Owner's done high for exactly this one cycle; no new grant is taken.
  - Next edge: done = 0, go to IDLE.
- Latency: request sampled at edge E0 -> done high in the cycle after edge E(WAIT_CYCLES+1).
- Throughput: one access per WAIT_CYCLES+3 cycles under continuous requests.
- Requests arriving during BUSY or DONE are held off. A new request from the non-owner is arbitrated at the next IDLE.
- Deassertion of the owner's request mid-BUSY is ignored; the latched access completes.
- p_stall is high from request assertion through the cycle before p_done. It is low in the p_done cycle so the pipeline advances. It is also low when the pipeline has no request.

Test Plan:
- Pipeline read, WAIT_CYCLES=2, p_addr=0x10, memory word 0xDEADBEEF -> mem_re high 3 cycles; p_done pulses once 3 cycles after request edge; p_rdata=0xDEADBEEF; p_stall high 3 cycles then low.
- Pipeline write p_addr=0x20, p_wdata=0x12345678 -> mem_we high 3 cycles with that addr/data; p_done pulse; subsequent read of 0x20 returns 0x12345678.
- Simultaneous p_re and d_re from IDLE -> pipeline served first; debug served at the next IDLE; d_done follows p_done by WAIT_CYCLES+3 cycles.
- STARVE_LIMIT=2, pipeline and debug continuously requesting -> grant order P,P,D,P,P,D; starve counter clears after each debug grant.
- rst asserted in the second BUSY cycle -> mem_re/mem_we drop immediately; no done pulse; after release a new p_re is served with full latency.
- p_re=p_we=1, p_wdata=0xA5A5A5A5 -> treated as write; mem_we=1, mem_re=0; p_rdata unchanged; p_done pulses.
